// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB chunk first.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CHUNK:0]   step;
  logic [WIDTH-1:0] diff_next;

  // Operands shift right so the active chunk is always at the bottom; each
  // result chunk enters at the top, so after NCHUNK cycles chunk i sits at
  // bits [i*CHUNK +: CHUNK].
  always_comb begin
    step      = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, borrow};
    diff_next = (diff_r >> CHUNK) | (WIDTH'(step[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      diff_r      <= '0;
      cnt         <= '0;
      borrow      <= 1'b0;
      bout_r      <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            borrow     <= bus.bin;
            cnt        <= '0;
            diff_r     <= '0;
            bout_r     <= 1'b0;
            zero_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb      <= bus.a[WIDTH-1];
            b_msb      <= bus.b[WIDTH-1];
            ovf_r      <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          borrow <= step[CHUNK];
          diff_r <= diff_next;
          if (cnt == LAST) begin
            bout_r      <= step[CHUNK];
            zero_r      <= (diff_next == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r       <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // zero is only meaningful alongside out_valid, so drop it on exit.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            zero_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.zero      = zero_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf       = ovf_r;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (32-bit, 8-bit chunks).
// Expected results come from a plain 33-bit subtraction model.
module tb_serial_subtractor;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   edges;
  exp_t sb[$];
  exp_t hold_exp;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    exp_t       e;
    logic [W:0] r;
    r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.zero = (r[W-1:0] == '0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    e.ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    sb.push_back(model(a, b, bin));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.bin      = 1'($urandom_range(0, 1));
    checkOutput("in_ready_in_run", {31'b0, bus.in_ready}, 32'd0);
  endtask

  task automatic waitOutValid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
  endtask

  task automatic consumeResult(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    checkOutput({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    checkOutput({tag, "_diff"}, bus.diff, e.diff);
    checkOutput({tag, "_bout"}, {31'b0, bus.bout}, {31'b0, e.bout});
    checkOutput({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, e.zero});
    checkOutput({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, e.ovf});
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_ret_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    checkOutput({tag, "_ret_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic runVector(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    applyStimulus(a, b, bin);
    waitOutValid(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd4);
    consumeResult(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_diff", bus.diff, 32'd0);
    checkOutput("rst_bout", {31'b0, bus.bout}, 32'd0);
    checkOutput("rst_zero", {31'b0, bus.zero}, 32'd0);
    checkOutput("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runVector("v_5m3", 32'h0000_0005, 32'h0000_0003, 1'b0);
    runVector("v_0m1", 32'h0000_0000, 32'h0000_0001, 1'b0);
    runVector("v_chunkborrow", 32'h0000_0100, 32'h0000_00FF, 1'b1);
    runVector("v_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0);
    runVector("v_negovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      runVector($sformatf("v_rand%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Back-pressure: result must hold while a new request is presented.
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    waitOutValid(edges);
    checkOutput("hold_latency", 32'(edges), 32'd4);
    hold_exp     = (sb.size() != 0) ? sb[0] : '0;
    bus.in_valid = 1'b1;
    bus.a        = 32'h1111_1111;
    bus.b        = 32'h0101_0101;
    bus.bin      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      checkOutput("hold_diff", bus.diff, hold_exp.diff);
      checkOutput("hold_bout", {31'b0, bus.bout}, {31'b0, hold_exp.bout});
    end
    consumeResult("hold");
    runVector("after_hold", 32'h1111_1111, 32'h0101_0101, 1'b0);

    // Reset during the second RUN cycle discards the in-flight operation.
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("midrst_diff", bus.diff, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runVector("post_rst", 32'h1234_5678, 32'h0234_5678, 1'b0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operands a, b, bin valid.
REQ-006 Port in_ready  output  1  block can accept operands.
REQ-007 Port a  input  WIDTH  minuend.
REQ-008 Port b  input  WIDTH  subtrahend.
REQ-009 Port bin  input  1  borrow-in.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-013 Port bout  output  1  borrow-out; 1 when unsigned a < b + bin.
REQ-014 Port zero  output  1  diff equals 0.
REQ-015 Port ovf  output  1  signed overflow (see Configuration).

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid && in_ready, the block SHALL register a, b, bin, clear the chunk counter, and enter RUN.
REQ-019 RUN: each cycle, the block SHALL compute chunk i as {borrow, d} = a[i] - b[i] - borrow (borrow initialised from bin), write d into diff bits [i*CHUNK +: CHUNK], and increment the counter.
REQ-020 RUN SHALL last exactly WIDTH/CHUNK cycles, least-significant chunk first; after the last chunk the block SHALL enter DONE.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH/CHUNK clock edges after the accepting edge (4 for defaults).
REQ-022 DONE: diff, bout, zero, ovf SHALL hold stable while out_valid && !out_ready.
REQ-023 DONE: on out_ready, the block SHALL return to IDLE at that edge; a new operand set SHALL NOT be accepted in the same cycle.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-025 bout SHALL equal the final chunk borrow; zero SHALL be valid in DONE only.
REQ-026 The chunk counter SHALL be sized ceil(log2(WIDTH/CHUNK)) bits minimum, with no wrap inside RUN.
REQ-027 The case WIDTH == CHUNK SHALL be supported as a single RUN cycle.

Reset
REQ-028 While rst_n is low, the FSM SHALL be in IDLE, with in_ready = 1, out_valid = 0, diff = 0, bout = 0, zero = 0, ovf = 0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation immediately with no partial result retained.
REQ-030 The first handshake after reset release SHALL be accepted on the first rising edge with in_valid high.

Configuration
REQ-031 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using registered operands, valid in DONE.
REQ-032 Without SERIAL_SUBTRACTOR_OVF_EN, the ovf port SHALL remain present and be tied to 0, with no overflow logic synthesised.

Verification
REQ-033 a=00000005, b=00000003, bin=0 -> diff=00000002, bout=0, zero=0; out_valid exactly 4 edges after acceptance.
REQ-034 a=00000000, b=00000001, bin=0 -> diff=FFFFFFFF, bout=1, zero=0.
REQ-035 a=00000100, b=000000FF, bin=1 -> diff=00000000, bout=0, zero=1 (checks borrow across chunk boundary).
REQ-036 a=80000000, b=00000001, bin=0 -> diff=7FFFFFFF, bout=0, ovf=1 with macro, ovf=0 without.
REQ-037 Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Drop rst_n during the 2nd RUN cycle -> out_valid=0 and in_ready=1 immediately; the next operation a=12345678, b=02345678 -> diff=10000000, bout=0.
